// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite to APB3 bridge fanning out to NUM_SLAVES peripherals selected by an HADDR index field.
// Define AHB_APB_TIMEOUT_EN to abort APB accesses that stall longer than TIMEOUT_CYCLES.
module ahb_apb_bridge_mc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_SEL_LSB    = 12,
  parameter int SLV_SEL_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic                             HSEL,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  input  logic                             HWRITE,
  input  logic [2:0]                       HSIZE,
  input  logic [DATA_WIDTH-1:0]            HWDATA,
  input  logic                             HREADY,
  output logic                             HREADYOUT,
  output logic [1:0]                       HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  output logic [2:0]                       BRIDGE_ERRORS
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR_1,
    ST_ERR_2
  } state_t;

  localparam logic [SLV_SEL_WIDTH:0] NUM_SLV = (SLV_SEL_WIDTH+1)'(NUM_SLAVES);

  state_t                    state;
  state_t                    state_nxt;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic                      write_q;
  logic [SLV_SEL_WIDTH-1:0]  idx_q;
  logic [2:0]                err_q;
  logic [2:0]                err_nxt;

  logic                      addr_valid;
  logic                      idx_in_range;
  logic                      capture;
  logic [SLV_SEL_WIDTH-1:0]  haddr_idx;
  logic                      sel_pready;
  logic                      sel_pslverr;
  logic [DATA_WIDTH-1:0]     sel_prdata;
  logic                      apb_active;
  logic                      timeout_hit;
  logic                      unused_bits;

  // Transfer size and the SEQ/NONSEQ distinction do not affect APB behaviour.
  assign unused_bits  = ^{HSIZE, HTRANS[0]};

  assign addr_valid   = HSEL && HREADY && HTRANS[1];
  assign haddr_idx    = HADDR[SLV_SEL_LSB +: SLV_SEL_WIDTH];
  assign idx_in_range = ({1'b0, haddr_idx} < NUM_SLV);

  // A new address phase is only taken when the bridge is not stalling the bus.
  assign capture = addr_valid &&
                   ((state == ST_IDLE) || (state == ST_ERR_2) ||
                    ((state == ST_ACCESS) && sel_pready && !sel_pslverr));

  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SLV_SEL_WIDTH'(i)) begin
        sel_pready  = PREADY[i];
        sel_pslverr = PSLVERR[i];
        sel_prdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef AHB_APB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCNT_W-1:0] tcnt;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tcnt <= '0;
    end else if (state == ST_SETUP) begin
      tcnt <= '0;
    end else if (state == ST_ACCESS) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // tcnt counts completed ACCESS cycles, so this fires in the last allowed one.
  assign timeout_hit = (state == ST_ACCESS) && !sel_pready &&
                       (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      err_q <= err_nxt;
      if (capture) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        idx_q   <= haddr_idx;
      end
    end
  end

  // err_nxt bits are {timeout, slverr, decerr}; registered so each shows as a clean one-cycle pulse.
  always_comb begin
    state_nxt = state;
    err_nxt   = '0;
    case (state)
      ST_IDLE, ST_ERR_2: begin
        if (addr_valid) begin
          if (idx_in_range) begin
            state_nxt = ST_SETUP;
          end else begin
            state_nxt  = ST_ERR_1;
            err_nxt[0] = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_pready) begin
          if (sel_pslverr) begin
            state_nxt  = ST_ERR_2;
            err_nxt[1] = 1'b1;
          end else if (addr_valid) begin
            if (idx_in_range) begin
              state_nxt = ST_SETUP;
            end else begin
              state_nxt  = ST_ERR_1;
              err_nxt[0] = 1'b1;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (timeout_hit) begin
          state_nxt  = ST_ERR_1;
          err_nxt[2] = 1'b1;
        end
      end
      ST_ERR_1: begin
        state_nxt = ST_ERR_2;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    HREADYOUT  = 1'b1;
    HRESP      = 2'b00;
    HRDATA     = '0;
    PENABLE    = 1'b0;
    apb_active = 1'b0;
    case (state)
      ST_SETUP: begin
        HREADYOUT  = 1'b0;
        apb_active = 1'b1;
      end
      ST_ACCESS: begin
        apb_active = 1'b1;
        PENABLE    = 1'b1;
        if (!sel_pready) begin
          HREADYOUT = 1'b0;
        end else if (sel_pslverr) begin
          HREADYOUT = 1'b0;
          HRESP     = 2'b01;
        end else if (!write_q) begin
          HRDATA = sel_prdata;
        end
      end
      ST_ERR_1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
      end
      ST_ERR_2: begin
        HRESP = 2'b01;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (apb_active && (idx_q == SLV_SEL_WIDTH'(i))) begin
        PSEL[i] = 1'b1;
      end
    end
  end

  // HWDATA stays stable for the whole APB transfer because the bridge holds HREADYOUT low.
  assign PWDATA        = (|PSEL) ? HWDATA : '0;
  assign PADDR         = addr_q;
  assign PWRITE        = write_q;
  assign BRIDGE_ERRORS = err_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// Scoreboard bench for ahb_apb_bridge_mc: directed AHB transfers against a simple APB slave model.
// Build with AHB_APB_TIMEOUT_EN defined to also exercise the stalled-slave timeout.
module tb_ahb_apb_bridge_mc;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           hsel;
  logic [AW-1:0]  haddr;
  logic [1:0]     htrans;
  logic           hwrite;
  logic [2:0]     hsize;
  logic [DW-1:0]  hwdata;
  logic           hready;
  logic           hreadyout;
  logic [1:0]     hresp;
  logic [DW-1:0]  hrdata;
  logic [AW-1:0]  paddr;
  logic [NS-1:0]  psel;
  logic           penable;
  logic           pwrite;
  logic [DW-1:0]  pwdata;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]  pready;
  logic [NS-1:0]  pslverr;
  logic [2:0]     bridge_errors;

  int             acc_cnt = 0;
  int             slv_wait;
  logic [NS-1:0]  slv_err_mask;
  logic [DW-1:0]  rd_tbl [NS];

  int nchecks = 0;
  int npass   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  psel;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    logic [2:0]  errs;
    int          gap;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  ahb_apb_bridge_mc #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_SLAVES(NS),
    .SLV_SEL_LSB(12),
    .SLV_SEL_WIDTH(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(clock),
    .HRESET(reset),
    .HSEL(hsel),
    .HADDR(haddr),
    .HTRANS(htrans),
    .HWRITE(hwrite),
    .HSIZE(hsize),
    .HWDATA(hwdata),
    .HREADY(hready),
    .HREADYOUT(hreadyout),
    .HRESP(hresp),
    .HRDATA(hrdata),
    .PADDR(paddr),
    .PSEL(psel),
    .PENABLE(penable),
    .PWRITE(pwrite),
    .PWDATA(pwdata),
    .PRDATA(prdata),
    .PREADY(pready),
    .PSLVERR(pslverr),
    .BRIDGE_ERRORS(bridge_errors)
  );

  // Single-master bus: the bridge is the only thing that can stall it.
  assign hready  = hreadyout;

  // APB slave model: a selected slave answers after slv_wait ACCESS cycles.
  assign pready  = psel & {NS{acc_cnt >= slv_wait}};
  assign pslverr = slv_err_mask;
  assign prdata  = {rd_tbl[3], rd_tbl[2], rd_tbl[1], rd_tbl[0]};

  always @(posedge clock) begin
    if (|psel && !penable) acc_cnt <= 0;
    else if (penable)      acc_cnt <= acc_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act === exp) npass++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Issue one address phase once the bus is ready, then present its write data.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                               input logic [3:0] e_psel, input int e_waits, input logic e_err,
                               input logic [31:0] e_rdata, input logic [2:0] e_errs, input int e_gap);
    exp_t e;
    int   n = 0;
    while (!hreadyout && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("bus_ready_bound", 32'(hreadyout), 32'd1);
    e.addr = addr; e.write = wr; e.wdata = wdata; e.psel = e_psel; e.waits = e_waits;
    e.err = e_err; e.rdata = e_rdata; e.errs = e_errs; e.gap = e_gap;
    sb.push_back(e);
    hsel   = 1'b1;
    haddr  = addr;
    hwrite = wr;
    htrans = 2'b10;
    @(posedge clock); #1;
    htrans = 2'b00;
    hwdata = wr ? wdata : 32'h0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
    checkOutput({tag, "_hresp"}, 32'(hresp), 32'd0);
    checkOutput({tag, "_hrdata"}, hrdata, 32'd0);
    checkOutput({tag, "_psel"}, 32'(psel), 32'd0);
    checkOutput({tag, "_penable"}, 32'(penable), 32'd0);
    checkOutput({tag, "_pwrite"}, 32'(pwrite), 32'd0);
    checkOutput({tag, "_paddr"}, paddr, 32'd0);
    checkOutput({tag, "_pwdata"}, pwdata, 32'd0);
    checkOutput({tag, "_errors"}, 32'(bridge_errors), 32'd0);
  endtask

  // Monitor: follows each data phase and compares against the head of the scoreboard on completion.
  initial begin
    bit         in_dphase = 0;
    int         waits = 0;
    int         err_cycles = 0;
    int         cyc = 0;
    int         last_done = 0;
    logic [1:0] prev_resp = 2'b00;
    logic [2:0] err_acc = 3'b000;
    exp_t       cur;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        in_dphase = 0;
        sb.delete();
      end else begin
        if (in_dphase) begin
          cur = sb[0];
          if (psel != 0) begin
            checkOutput("psel_onehot", 32'($onehot(psel)), 32'd1);
            checkOutput("psel", 32'(psel), 32'(cur.psel));
            checkOutput("paddr", paddr, cur.addr);
            checkOutput("pwrite", 32'(pwrite), 32'(cur.write));
            if (cur.write) checkOutput("pwdata", pwdata, cur.wdata);
          end else begin
            checkOutput("penable_without_psel", 32'(penable), 32'd0);
            checkOutput("pwdata_unselected", pwdata, 32'd0);
          end
          if (bridge_errors != 3'b000) begin
            err_acc = err_acc | bridge_errors;
            err_cycles++;
          end
          if (!hreadyout) begin
            waits++;
            prev_resp = hresp;
            checkOutput("hrdata_during_wait", hrdata, 32'd0);
          end else begin
            checkOutput("wait_cycles", 32'(waits), 32'(cur.waits));
            checkOutput("hresp_final", 32'(hresp), cur.err ? 32'd1 : 32'd0);
            checkOutput("hresp_last_wait", 32'(prev_resp), cur.err ? 32'd1 : 32'd0);
            checkOutput("hrdata", hrdata, cur.rdata);
            checkOutput("bridge_errors", 32'(err_acc), 32'(cur.errs));
            checkOutput("error_pulse_cycles", 32'(err_cycles), (cur.errs != 0) ? 32'd1 : 32'd0);
            if (cur.gap != 0) checkOutput("completion_gap", 32'(cyc - last_done), 32'(cur.gap));
            last_done = cyc;
            void'(sb.pop_front());
            in_dphase = 0;
          end
        end
        if (hsel && hready && htrans[1]) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_transfer", 32'd1, 32'd0);
          end else begin
            in_dphase  = 1;
            waits      = 0;
            err_cycles = 0;
            err_acc    = 3'b000;
            prev_resp  = 2'b00;
          end
        end
      end
    end
  end

  initial begin
    int n;
    hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 3'b010; hwdata = 0;
    slv_wait = 0; slv_err_mask = '0;
    rd_tbl[0] = 32'hC0DE_0000; rd_tbl[1] = 32'h0000_1234;
    rd_tbl[2] = 32'h2222_5555; rd_tbl[3] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clock);
    #1;
    checkResetValues("reset");
    reset = 0;
    @(posedge clock); #1;

    $display("[TB] IDLE and BUSY transfers, even to an unmapped slot, are ignored");
    hsel = 1; haddr = 32'h0000_9000; htrans = 2'b00;
    @(posedge clock); #1;
    checkOutput("idle_hreadyout", 32'(hreadyout), 32'd1);
    checkOutput("idle_psel", 32'(psel), 32'd0);
    htrans = 2'b01;
    @(posedge clock); #1;
    checkOutput("busy_hresp", 32'(hresp), 32'd0);
    checkOutput("busy_errors", 32'(bridge_errors), 32'd0);
    htrans = 2'b00;

    $display("[TB] write slave 2, zero wait");
    applyStimulus(32'h0000_2004, 1'b1, 32'hA5, 4'b0100, 1, 1'b0, 32'h0, 3'b000, 0);
    waitDrain();

    $display("[TB] read slave 1 with three wait states");
    slv_wait = 3;
    applyStimulus(32'h0000_1000, 1'b0, 32'h0, 4'b0010, 4, 1'b0, 32'h0000_1234, 3'b000, 0);
    waitDrain();

    $display("[TB] write slave 0 answered with PSLVERR");
    slv_wait = 0; slv_err_mask = 4'b0001;
    applyStimulus(32'h0000_0010, 1'b1, 32'h5A, 4'b0001, 2, 1'b1, 32'h0, 3'b010, 0);
    waitDrain();
    slv_err_mask = 4'b0000;

    $display("[TB] unmapped slave index 9");
    applyStimulus(32'h0000_9000, 1'b0, 32'h0, 4'b0000, 1, 1'b1, 32'h0, 3'b001, 0);
    waitDrain();

    $display("[TB] back-to-back writes to slaves 0 and 3");
    applyStimulus(32'h0000_0008, 1'b1, 32'h11, 4'b0001, 1, 1'b0, 32'h0, 3'b000, 0);
    applyStimulus(32'h0000_300C, 1'b1, 32'h33, 4'b1000, 1, 1'b0, 32'h0, 3'b000, 2);
    waitDrain();

    $display("[TB] reads of slaves 3 and 0 check the PRDATA mux");
    slv_wait = 1;
    applyStimulus(32'h0000_3000, 1'b0, 32'h0, 4'b1000, 2, 1'b0, 32'hDEAD_BEEF, 3'b000, 0);
    waitDrain();
    slv_wait = 0;
    applyStimulus(32'h0000_0004, 1'b0, 32'h0, 4'b0001, 1, 1'b0, 32'hC0DE_0000, 3'b000, 0);
    waitDrain();

`ifdef AHB_APB_TIMEOUT_EN
    $display("[TB] slave 2 never ready, timeout after 8 ACCESS cycles");
    slv_wait = 1000;
    applyStimulus(32'h0000_2000, 1'b0, 32'h0, 4'b0100, 10, 1'b1, 32'h0, 3'b100, 0);
    waitDrain();
    slv_wait = 0;
`endif

    $display("[TB] reset during ACCESS abandons the transfer");
    slv_wait = 20;
    applyStimulus(32'h0000_1008, 1'b1, 32'h77, 4'b0010, 21, 1'b0, 32'h0, 3'b000, 0);
    n = 0;
    while (!penable && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("penable_before_reset", 32'(penable), 32'd1);
    reset = 1;
    @(posedge clock); #1;
    checkResetValues("midreset");
    reset = 0;
    slv_wait = 0;
    @(posedge clock); #1;

    $display("[TB] read slave 2 after reset");
    applyStimulus(32'h0000_2000, 1'b0, 32'h0, 4'b0100, 1, 1'b0, 32'h2222_5555, 3'b000, 0);
    waitDrain();

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
